// File: rtl/video_capture.sv
// Video capture receiver: registers an incoming RGB/HS/VS/BLANK stream on
// pixel_clk and pushes the active pixels through an async FIFO. On the
// Wishbone clock it writes each pixel as a single classic write into a frame
// buffer at BASE_ADR. It also keeps per-frame integrity status.

// Dual-clock FIFO with gray-coded pointers. rdata is valid whenever rempty=0
// (first-word-fall-through), and asserting read pops the head word.
module async_fifo #(
  parameter int DATA_WIDTH = 33,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wbin, wgray, rbin, rgray;
  logic [ADDR_WIDTH:0]   wq1_rgray, wq2_rgray, rq1_wgray, rq2_wgray;
  logic [ADDR_WIDTH:0]   wbin_next, rbin_next;

  assign wbin_next = wbin + ONE;
  assign rbin_next = rbin + ONE;
  assign wfull  = (wgray == {~wq2_rgray[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rgray[ADDR_WIDTH-2:0]});
  assign rempty = (rgray == rq2_wgray);
  assign rdata  = mem[rbin[ADDR_WIDTH-1:0]];

  // Storage write; the array is not reset, because the pointers define what is valid.
  always_ff @(posedge wclk)
    if (write && !wfull) mem[wbin[ADDR_WIDTH-1:0]] <= wdata;

  // Write pointer, plus a two-flop synchroniser that brings the read pointer into this domain.
  always_ff @(posedge wclk or posedge rst)
    if (rst) begin
      wbin <= '0; wgray <= '0; wq1_rgray <= '0; wq2_rgray <= '0;
    end else begin
      if (write && !wfull) begin
        wbin  <= wbin_next;
        wgray <= wbin_next ^ (wbin_next >> 1);
      end
      wq1_rgray <= rgray;
      wq2_rgray <= wq1_rgray;
    end

  // Read pointer, plus a two-flop synchroniser that brings the write pointer into this domain.
  always_ff @(posedge rclk or posedge rst)
    if (rst) begin
      rbin <= '0; rgray <= '0; rq1_wgray <= '0; rq2_wgray <= '0;
    end else begin
      if (read && !rempty) begin
        rbin  <= rbin_next;
        rgray <= rbin_next ^ (rbin_next >> 1);
      end
      rq1_wgray <= wgray;
      rq2_wgray <= rq1_wgray;
    end
endmodule

// Pixel FSM
//   state   | meaning
//   WAIT_VS | idle, waiting for a VS rising edge with capture_en set
//   CAPTURE | pushing active pixels of the current frame
// Wishbone FSM
//   IDLE    | bus released, waiting for a FIFO word
//   WRITE   | single write in flight, held until ack
module video_capture #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int          FIFO_AW  = 4
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [23:0] rgb,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
  input  logic        capture_en,
  output logic        overflow,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  input  logic        wb_clk,
  input  logic        wb_rst,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_ms,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic        wb_ack
);
  localparam int TOTAL = HDISP * VDISP;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam logic [PW-1:0] PIX_FULL = PW'(TOTAL);
  localparam logic [29:0]   LAST_ID  = 30'(TOTAL - 1);

  typedef enum logic {WAIT_VS, CAPTURE} pix_state_t;
  typedef enum logic {IDLE, WRITE} wb_state_t;

  pix_state_t    pix_state, pix_state_n;
  logic [23:0]   rgb_q;
  logic          hs_q, vs_q, vs_d, blank_q;
  logic [PW-1:0] pix_cnt, pix_cnt_n;
  logic [15:0]   frame_cnt_n;
  logic          overflow_n, frame_err_n;
  logic          frame_start, active, push, wfull;
  logic [32:0]   wdata, rdata;
  logic          rempty, fifo_read, fifo_rst;

  wb_state_t     wb_state, wb_state_n;
  logic [29:0]   word_id;
  logic [31:0]   dat_q;

  assign fifo_rst    = wb_rst | pixel_rst;
  assign frame_start = vs_q & ~vs_d;
  // A pixel flagged active during the horizontal sync pulse is treated as blanking.
  assign active      = blank_q & hs_q;
  assign wdata       = {(pix_cnt == '0), 8'h00, rgb_q};

  // Input register stage. Sync is held at its idle level so that reset does not produce a false VS edge.
  always_ff @(posedge pixel_clk or posedge pixel_rst)
    if (pixel_rst) begin
      rgb_q <= '0; hs_q <= 1'b1; vs_q <= 1'b1; vs_d <= 1'b1; blank_q <= 1'b0;
    end else begin
      rgb_q <= rgb; hs_q <= hs; vs_q <= vs; vs_d <= vs_q; blank_q <= blank;
    end

  // Pixel FSM state and status registers.
  always_ff @(posedge pixel_clk or posedge pixel_rst)
    if (pixel_rst) begin
      pix_state <= WAIT_VS; pix_cnt <= '0; frame_cnt <= '0;
      overflow <= 1'b0; frame_err <= 1'b0;
    end else begin
      pix_state <= pix_state_n; pix_cnt <= pix_cnt_n; frame_cnt <= frame_cnt_n;
      overflow <= overflow_n; frame_err <= frame_err_n;
    end

  // Pixel FSM next state. A frame boundary takes priority over any pixel sampled in the same cycle.
  always_comb begin
    pix_state_n = pix_state;
    pix_cnt_n   = pix_cnt;
    frame_cnt_n = frame_cnt;
    overflow_n  = overflow;
    frame_err_n = frame_err;
    push        = 1'b0;
    case (pix_state)
      WAIT_VS:
        if (frame_start && capture_en) begin
          pix_state_n = CAPTURE;
          pix_cnt_n   = '0;
        end
      CAPTURE:
        if (frame_start) begin
          if (pix_cnt == PIX_FULL) frame_cnt_n = frame_cnt + 16'd1;
          else                     frame_err_n = 1'b1;
          pix_cnt_n = '0;
          if (!capture_en) pix_state_n = WAIT_VS;
        end else if (active && pix_cnt != PIX_FULL) begin
          if (wfull) begin
            overflow_n  = 1'b1;
            pix_state_n = WAIT_VS;
          end else begin
            push      = 1'b1;
            pix_cnt_n = pix_cnt + PW'(1);
          end
        end
      default: pix_state_n = WAIT_VS;
    endcase
  end

  async_fifo #(.DATA_WIDTH(33), .ADDR_WIDTH(FIFO_AW)) u_fifo (
    .wclk(pixel_clk), .rclk(wb_clk), .rst(fifo_rst),
    .write(push), .wdata(wdata), .read(fifo_read),
    .rdata(rdata), .wfull(wfull), .rempty(rempty)
  );

  // Wishbone FSM state register.
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) wb_state <= IDLE;
    else        wb_state <= wb_state_n;

  // Wishbone FSM next state. Exactly one FIFO word is popped per write.
  always_comb begin
    wb_state_n = wb_state;
    fifo_read  = 1'b0;
    case (wb_state)
      IDLE:
        if (!rempty) begin
          fifo_read  = 1'b1;
          wb_state_n = WRITE;
        end
      WRITE:
        if (wb_ack) wb_state_n = IDLE;
      default: wb_state_n = IDLE;
    endcase
  end

  // Latch the popped word. A start-of-frame marker realigns the address, and this takes priority over the wrap.
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) begin
      word_id <= '0; dat_q <= '0;
    end else if (wb_state == IDLE && !rempty) begin
      dat_q <= rdata[31:0];
      if (rdata[32]) word_id <= '0;
    end else if (wb_state == WRITE && wb_ack) begin
      word_id <= (word_id == LAST_ID) ? '0 : word_id + 30'd1;
    end

  assign wb_cyc    = (wb_state == WRITE);
  assign wb_stb    = wb_cyc;
  assign wb_we     = wb_cyc;
  assign wb_adr    = BASE_ADR + {word_id, 2'b00};
  assign wb_dat_ms = dat_q;
  assign wb_sel    = 4'hF;
  assign wb_cti    = 3'b000;
  assign wb_bte    = 2'b00;
endmodule
